// File: rtl/carry4_nibble_seq.sv
// carry4_nibble_seq: drives one external CARRY4 slice nibble by nibble to
// build a 4*NIB-bit add/subtract. An optional 65C02-style decimal correction
// pass re-uses the same slice.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; req_ready high, slice inputs parked at 0
// SUM   | binary pass on nibble k through the slice
// ADJ   | decimal correction of nibble k (+6 for add, -6 for sub)
// DONE  | response presented; held until rsp_ready
module carry4_nibble_seq #(
    parameter int NIB    = 2,
    parameter int DEC_EN = 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_sub,
    input  logic              req_dec,
    input  logic              req_ci,
    input  logic [4*NIB-1:0]  req_a,
    input  logic [4*NIB-1:0]  req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [4*NIB-1:0]  rsp_res,
    output logic              rsp_c,
    output logic              rsp_v,
    output logic              rsp_n,
    output logic              rsp_z,
    output logic              cy_ci,
    output logic [3:0]        cy_di,
    output logic [3:0]        cy_s,
    input  logic [3:0]        cy_co,
    input  logic [3:0]        cy_o
);

    localparam int         W      = 4 * NIB;
    localparam logic [1:0] K_LAST = 2'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;

    // a_q holds operand A and is overwritten in place with the result nibbles.
    // b_q is stored already inverted for subtract.
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           sub_q;
    logic           dec_q;
    logic           carry_q;
    logic           v_q;
    logic [1:0]     k_q;

    logic [3:0]     nib_a;
    logic [3:0]     nib_b;
    logic           k_last;
    logic           adj_need;

    // Select nibble k of both operands (constant-index mux, NIB is small).
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIB; i++) begin
            if (k_q == 2'(i)) begin
                nib_a = a_q[i*4 +: 4];
                nib_b = b_q[i*4 +: 4];
            end
        end
        k_last = (k_q == K_LAST);
        // Add: decimal carry or digit above 9. Sub: a borrow means the digit wrapped.
        adj_need = sub_q ? ~cy_co[3] : (cy_co[3] | (cy_o > 4'd9));
    end

    // Next-state decode, slice drive and response outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_res   = '0;
        rsp_c     = 1'b0;
        rsp_v     = 1'b0;
        rsp_n     = 1'b0;
        rsp_z     = 1'b0;
        cy_ci     = 1'b0;
        cy_di     = 4'h0;
        cy_s      = 4'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = SUM;
                end
            end
            SUM: begin
                cy_di = nib_a;
                cy_s  = nib_a ^ nib_b;
                cy_ci = carry_q;
                if (dec_q && adj_need) begin
                    state_nxt = ADJ;
                end else if (k_last) begin
                    state_nxt = DONE;
                end
            end
            ADJ: begin
                // DI = nibble with S = nibble ^ X adds X; 0xA is -6 mod 16.
                cy_di = nib_a;
                cy_s  = nib_a ^ (sub_q ? 4'hA : 4'h6);
                state_nxt = k_last ? DONE : SUM;
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_res   = a_q;
                rsp_c     = carry_q;
                rsp_v     = v_q;
                rsp_n     = a_q[W-1];
                rsp_z     = (a_q == '0);
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus operand capture and per-nibble result write-back.
    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            dec_q   <= 1'b0;
            carry_q <= 1'b0;
            v_q     <= 1'b0;
            k_q     <= 2'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q     <= req_a;
                        b_q     <= req_sub ? ~req_b : req_b;
                        sub_q   <= req_sub;
                        dec_q   <= req_dec & (DEC_EN != 0);
                        carry_q <= req_ci;
                        v_q     <= 1'b0;
                        k_q     <= 2'd0;
                    end
                end
                SUM: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (k_q == 2'(i)) begin
                            a_q[i*4 +: 4] <= cy_o;
                        end
                    end
                    carry_q <= cy_co[3];
                    // Overflow reflects the binary pass only; adjust never touches it.
                    if (k_last) begin
                        v_q <= cy_co[3] ^ cy_co[2];
                    end
                    if (!(dec_q && adj_need) && !k_last) begin
                        k_q <= k_q + 2'd1;
                    end
                end
                ADJ: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (k_q == 2'(i)) begin
                            a_q[i*4 +: 4] <= cy_o;
                        end
                    end
                    // Slice carry is meaningless here: a decimal add always
                    // carries after correction, a decimal sub keeps its borrow.
                    if (!sub_q) begin
                        carry_q <= 1'b1;
                    end
                    if (!k_last) begin
                        k_q <= k_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_carry4_nibble_seq.sv
// Bench for carry4_nibble_seq: two instances (NIB=2 decimal, NIB=4 binary-only),
// each wired to a behavioural CARRY4 slice, with queue-based response checking.
module tb_carry4_nibble_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic        c, v, n, z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];

    // CARRY4 primitive: O = S ^ carry-in, carry passes when S=1, else DI.
    function automatic logic [7:0] carry4(input logic ci, input logic [3:0] di, input logic [3:0] s);
        logic       c;
        logic [3:0] o, co;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            o[i]  = s[i] ^ c;
            c     = s[i] ? c : di[i];
            co[i] = c;
        end
        return {co, o};
    endfunction

    // NIB=2, DEC_EN=1 instance
    logic        d2_req_valid = 1'b0, d2_req_ready, d2_sub = 1'b0, d2_dec = 1'b0, d2_ci = 1'b0;
    logic [7:0]  d2_a = '0, d2_b = '0, d2_res;
    logic        d2_rsp_valid, d2_rsp_ready = 1'b1, d2_c, d2_v, d2_n, d2_z;
    logic        d2_cy_ci;
    logic [3:0]  d2_cy_di, d2_cy_s, d2_cy_co, d2_cy_o;
    assign {d2_cy_co, d2_cy_o} = carry4(d2_cy_ci, d2_cy_di, d2_cy_s);

    carry4_nibble_seq #(.NIB(2), .DEC_EN(1)) u_d2 (
        .clk(clk), .RST(rst),
        .req_valid(d2_req_valid), .req_ready(d2_req_ready),
        .req_sub(d2_sub), .req_dec(d2_dec), .req_ci(d2_ci),
        .req_a(d2_a), .req_b(d2_b),
        .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready),
        .rsp_res(d2_res), .rsp_c(d2_c), .rsp_v(d2_v), .rsp_n(d2_n), .rsp_z(d2_z),
        .cy_ci(d2_cy_ci), .cy_di(d2_cy_di), .cy_s(d2_cy_s),
        .cy_co(d2_cy_co), .cy_o(d2_cy_o)
    );

    // NIB=4, DEC_EN=0 instance
    logic        d4_req_valid = 1'b0, d4_req_ready, d4_sub = 1'b0, d4_dec = 1'b0, d4_ci = 1'b0;
    logic [15:0] d4_a = '0, d4_b = '0, d4_res;
    logic        d4_rsp_valid, d4_rsp_ready = 1'b1, d4_c, d4_v, d4_n, d4_z;
    logic        d4_cy_ci;
    logic [3:0]  d4_cy_di, d4_cy_s, d4_cy_co, d4_cy_o;
    assign {d4_cy_co, d4_cy_o} = carry4(d4_cy_ci, d4_cy_di, d4_cy_s);

    carry4_nibble_seq #(.NIB(4), .DEC_EN(0)) u_d4 (
        .clk(clk), .RST(rst),
        .req_valid(d4_req_valid), .req_ready(d4_req_ready),
        .req_sub(d4_sub), .req_dec(d4_dec), .req_ci(d4_ci),
        .req_a(d4_a), .req_b(d4_b),
        .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready),
        .rsp_res(d4_res), .rsp_c(d4_c), .rsp_v(d4_v), .rsp_n(d4_n), .rsp_z(d4_z),
        .cy_ci(d4_cy_ci), .cy_di(d4_cy_di), .cy_s(d4_cy_s),
        .cy_co(d4_cy_co), .cy_o(d4_cy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor for the NIB=2 instance.
    logic d2_prev = 1'b0;
    exp_t m2;
    always @(negedge clk) begin
        if (d2_rsp_valid) begin
            if (q2.size() == 0) begin
                if (!d2_prev) begin
                    checks++;
                    failures++;
                    $display("FAIL d2_unexpected_rsp actual=res 0x%0h required=no response", d2_res);
                end
            end else begin
                if (!d2_prev) chk("d2_latency", 32'(cyc - q2[0].acc), 32'(q2[0].lat));
                if (d2_rsp_ready) begin
                    m2 = q2.pop_front();
                    chk("d2_res", 32'(d2_res), 32'(m2.res[7:0]));
                    chk("d2_c", 32'(d2_c), 32'(m2.c));
                    chk("d2_v", 32'(d2_v), 32'(m2.v));
                    chk("d2_n", 32'(d2_n), 32'(m2.n));
                    chk("d2_z", 32'(d2_z), 32'(m2.z));
                end
            end
        end
        d2_prev = d2_rsp_valid && !d2_rsp_ready;
    end

    // Monitor for the NIB=4 instance.
    logic d4_prev = 1'b0;
    exp_t m4;
    always @(negedge clk) begin
        if (d4_rsp_valid) begin
            if (q4.size() == 0) begin
                if (!d4_prev) begin
                    checks++;
                    failures++;
                    $display("FAIL d4_unexpected_rsp actual=res 0x%0h required=no response", d4_res);
                end
            end else begin
                if (!d4_prev) chk("d4_latency", 32'(cyc - q4[0].acc), 32'(q4[0].lat));
                if (d4_rsp_ready) begin
                    m4 = q4.pop_front();
                    chk("d4_res", 32'(d4_res), 32'(m4.res));
                    chk("d4_c", 32'(d4_c), 32'(m4.c));
                    chk("d4_v", 32'(d4_v), 32'(m4.v));
                    chk("d4_n", 32'(d4_n), 32'(m4.n));
                    chk("d4_z", 32'(d4_z), 32'(m4.z));
                end
            end
        end
        d4_prev = d4_rsp_valid && !d4_rsp_ready;
    end

    // Issue one request on the NIB=2 instance and push its hand-computed response.
    // Called at #1 after a rising edge.
    task automatic op2(input logic sub, input logic dec, input logic ci,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic c, input logic v,
                       input logic n, input logic z, input int lat);
        exp_t e;
        int   nw = 0;
        while (!d2_req_ready && nw < 60) begin @(posedge clk); #1; nw++; end
        chk("d2_req_ready_before_issue", 32'(d2_req_ready), 32'd1);
        d2_sub = sub; d2_dec = dec; d2_ci = ci; d2_a = a; d2_b = b;
        d2_req_valid = 1'b1;
        @(posedge clk); #1;
        d2_req_valid = 1'b0;
        e.res = {8'h00, res}; e.c = c; e.v = v; e.n = n; e.z = z;
        e.lat = lat;
        e.acc = cyc - 1;   // edges before the accept edge
        q2.push_back(e);
    endtask

    task automatic op4(input logic sub, input logic dec, input logic ci,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic c, input logic v,
                       input logic n, input logic z, input int lat);
        exp_t e;
        int   nw = 0;
        while (!d4_req_ready && nw < 60) begin @(posedge clk); #1; nw++; end
        chk("d4_req_ready_before_issue", 32'(d4_req_ready), 32'd1);
        d4_sub = sub; d4_dec = dec; d4_ci = ci; d4_a = a; d4_b = b;
        d4_req_valid = 1'b1;
        @(posedge clk); #1;
        d4_req_valid = 1'b0;
        e.res = res; e.c = c; e.v = v; e.n = n; e.z = z;
        e.lat = lat;
        e.acc = cyc - 1;
        q4.push_back(e);
    endtask

    task automatic wait2();
        int nw = 0;
        while (q2.size() != 0 && nw < 60) begin @(posedge clk); #1; nw++; end
        if (q2.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL d2_timeout actual=%0d pending required=0 pending", q2.size());
            q2.delete();
        end
    endtask

    task automatic wait4();
        int nw = 0;
        while (q4.size() != 0 && nw < 60) begin @(posedge clk); #1; nw++; end
        if (q4.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL d4_timeout actual=%0d pending required=0 pending", q4.size());
            q4.delete();
        end
    endtask

    initial begin
        int nw;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_d2_req_ready", 32'(d2_req_ready), 32'd1);
        chk("rst_d2_rsp_valid", 32'(d2_rsp_valid), 32'd0);
        chk("rst_d2_res", 32'(d2_res), 32'd0);
        chk("rst_d2_flags", 32'({d2_c, d2_v, d2_n, d2_z}), 32'd0);
        chk("rst_d2_cy", 32'({d2_cy_ci, d2_cy_di, d2_cy_s}), 32'd0);
        chk("rst_d4_req_ready", 32'(d4_req_ready), 32'd1);
        chk("rst_d4_rsp", 32'({d4_rsp_valid, d4_res, d4_c, d4_v, d4_n, d4_z}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Binary add 0x7F+0x01: signed overflow into 0x80.
        op2(1'b0, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        wait2();
        // Binary sub 0x00-0x01: borrow, wraps to 0xFF.
        op2(1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        wait2();

        // Decimal add 58+46+1 = 105 with a 4-cycle response stall.
        d2_rsp_ready = 1'b0;
        op2(1'b0, 1'b1, 1'b1, 8'h58, 8'h46, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 5);
        nw = 0;
        while (!d2_rsp_valid && nw < 60) begin @(posedge clk); #1; nw++; end
        for (int i = 0; i < 4; i++) begin
            chk("stall_rsp_valid", 32'(d2_rsp_valid), 32'd1);
            chk("stall_req_ready", 32'(d2_req_ready), 32'd0);
            chk("stall_res", 32'(d2_res), 32'h05);
            chk("stall_c", 32'(d2_c), 32'd1);
            chk("stall_cy_idle", 32'({d2_cy_ci, d2_cy_di, d2_cy_s}), 32'd0);
            @(posedge clk); #1;
        end
        d2_rsp_ready = 1'b1;
        wait2();
        @(posedge clk); #1;
        chk("b2b_req_ready", 32'(d2_req_ready), 32'd1);

        // Decimal sub 40-13 = 27: only the low digit needs correction.
        op2(1'b1, 1'b1, 1'b1, 8'h40, 8'h13, 8'h27, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        wait2();

        // Reset while in SUM: the operation is dropped.
        d2_sub = 1'b0; d2_dec = 1'b0; d2_ci = 1'b1; d2_a = 8'h12; d2_b = 8'h34;
        d2_req_valid = 1'b1;
        @(posedge clk); #1;
        d2_req_valid = 1'b0;
        chk("sum_cy_di", 32'(d2_cy_di), 32'h2);
        chk("sum_cy_s", 32'(d2_cy_s), 32'h6);
        chk("sum_cy_ci", 32'(d2_cy_ci), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_req_ready", 32'(d2_req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(d2_rsp_valid), 32'd0);
        chk("abort_cy_idle", 32'({d2_cy_ci, d2_cy_di, d2_cy_s}), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_still_idle", 32'({d2_rsp_valid, d2_req_ready}), 32'b01);

        // Fresh decimal op after the abort: 19+28 = 47, low digit adjusted only.
        op2(1'b0, 1'b1, 1'b0, 8'h19, 8'h28, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        wait2();

        // DEC_EN=0 ignores req_dec: 0x0009+0x0001 stays binary.
        op4(1'b0, 1'b1, 1'b0, 16'h0009, 16'h0001, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        wait4();
        // Full-width wrap: 0xFFFF+1 = 0 with carry, zero flag set.
        op4(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 5);
        wait4();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carry4_nibble_seq.md
Name: carry4_nibble_seq

Overview:
- Sequencer that time-shares a single external CARRY4 ripple slice to perform multi-nibble add/subtract, one nibble per cycle.
- Performs optional 65C02-style decimal (BCD) adjust passes on the same slice.
- Sits between the microcode ALU control and the CARRY4 primitive.
- Accepts an operation via a valid/ready handshake and returns the result and flags via a valid/ready handshake.

Parameters:
- NIB, 2, number of 4-bit nibbles per operand (operand width W = 4*NIB); legal range 1..4.
- DEC_EN, 1, 1 = decimal mode honoured; 0 = req_dec ignored (binary only).

Ports:
- clk, input, 1, clock.
- RST, input, 1, synchronous active-high reset.
- req_valid, input, 1, operation offered.
- req_ready, output, 1, high only in IDLE.
- req_sub, input, 1, 0 = A+B+ci; 1 = A-B-!ci (B inverted).
- req_dec, input, 1, decimal mode.
- req_ci, input, 1, carry in.
- req_a, input, W, operand A.
- req_b, input, W, operand B.
- rsp_valid, output, 1, result available.
- rsp_ready, input, 1, result consumed.
- rsp_res, output, W, result.
- rsp_c, output, 1, carry out.
- rsp_v, output, 1, overflow.
- rsp_n, output, 1, result MSB.
- rsp_z, output, 1, result == 0.
- cy_ci, output, 1, to CARRY4 CI (CYINIT tied 0 externally).
- cy_di, output, 4, to CARRY4 DI.
- cy_s, output, 4, to CARRY4 S.
- cy_co, input, 4, from CARRY4 CO.
- cy_o, input, 4, from CARRY4 O.

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_res=0, rsp_c=0, rsp_v=0, rsp_n=0, rsp_z=0, cy_* outputs=0.
- Accept: req_valid & req_ready at a rising edge. All operands, op bits and carry are captured. Nibble index k=0. Running carry = req_ci. Effective decimal flag = req_dec & DEC_EN.
- States: IDLE, SUM, ADJ, DONE.
- IDLE -> SUM on accept.
- SUM (combinational drive): cy_di = A[k]; cy_s = A[k] ^ B'[k], where B' = ~B if sub; cy_ci = running carry.
- SUM register step: nibble k <= cy_o; carry <= cy_co[3].
  - When k == NIB-1, also latch v = cy_co[3] ^ cy_co[2].
- SUM transitions:
  - If decimal & adjust-needed -> ADJ.
  - Else if k == NIB-1 -> DONE.
  - Else k++, stay in SUM.
- Adjust-needed:
  - Add: cy_co[3] | (cy_o > 9).
  - Sub: !cy_co[3] (borrow).
- ADJ (combinational drive): cy_di = nibble; cy_ci = 0; cy_s = nibble ^ 4'h6 (add) or nibble ^ 4'hA (sub).
- ADJ register step: nibble <= cy_o. Carry is forced to 1 for add; unchanged (0) for sub. Slice carry out is ignored.
- ADJ transitions: k == NIB-1 -> DONE, else k++ -> SUM.
- DONE:
  - rsp_valid = 1.
  - rsp_c = final carry.
  - rsp_n = res[W-1].
  - rsp_z = (res == 0), computed on the final adjusted result.
  - rsp_v = binary-pass value, unchanged by adjust.
  - DONE -> IDLE when rsp_ready. Outputs hold stable while rsp_valid & !rsp_ready.
- Latency, accept edge to rsp_valid: binary NIB+1 cycles; decimal up to 2*NIB+1 cycles.
- Back-to-back: after DONE, req_ready is high in the cycle following the rsp handshake; no overlap.
- cy_* outputs are 0 in IDLE and DONE.
- RST in any state: immediate return to IDLE. rsp_valid drops the next cycle; the in-flight operation is discarded.
- req inputs are don't-care outside the accept cycle.

Test Plan:
- Binary add, NIB=2: A=0x7F, B=0x01, ci=0 -> res=0x80, c=0, v=1, n=1, z=0; rsp_valid exactly 3 cycles after accept.
- Binary sub: A=0x00, B=0x01, sub=1, ci=1 -> res=0xFF, c=0 (borrow), v=0, n=1.
- Decimal add: A=0x58, B=0x46, ci=1, dec=1 -> res=0x05, c=1, z=0; both nibbles pass through ADJ (5 cycles).
- Decimal sub: A=0x40, B=0x13, ci=1, dec=1, sub=1 -> res=0x27, c=1; only the low nibble is adjusted.
- Handshake and reset:
  - Hold rsp_ready=0 for 4 cycles -> outputs stable, req_ready=0.
  - Assert RST during SUM -> next cycle IDLE, rsp_valid=0, req_ready=1.
  - A new op then completes correctly.
- DEC_EN=0 with dec=1: A=0x09, B=0x01 -> res=0x0A (no adjust).
- NIB=4: A=0xFFFF, B=0x0001 -> res=0x0000, c=1, z=1.
